demux_buf: RTL

DEMUX_BUF -- requirements
Module: demux_buf

---
 rtl/demux_buf.sv | 95 +++++++++
 1 files changed

// File: rtl/demux_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux_buf
// Purpose  : 1:2 or 1:4 demultiplexer. Each destination has a one-word slot.
// Revision : 1.0 - initial release
// ============================================================================
module demux_buf #(
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  input  logic [S-1:0] i_sel,
  output logic         o_ready,
  output logic [N-1:0] o_a,
  output logic [N-1:0] o_b,
  output logic [N-1:0] o_c,
  output logic [N-1:0] o_d,
  output logic [3:0]   o_valid,
  input  logic [3:0]   i_ready,
  output logic [15:0]  o_cnt
);

  localparam int c_num_dst = 1 << S;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  if (S < 1 || S > 2) begin : g_bad_sel_width
    $error("%m: unsupported select width S=%0d (must be 1 or 2)", S);
  end

  slot_e        slot_q [4];
  slot_e        slot_d [4];
  logic [N-1:0] data_q [4];
  logic [N-1:0] data_d [4];
  logic [15:0]  cnt_q;
  logic [15:0]  cnt_d;
  logic [1:0]   sel_idx;
  logic         src_xfer;

  assign sel_idx = 2'(i_sel);

  always_comb begin
    // A full slot can still accept when its destination drains on the same edge.
    o_ready  = i_rst_n && ((slot_q[sel_idx] == EMPTY) || i_ready[sel_idx]);
    src_xfer = i_valid && o_ready;
    cnt_d    = cnt_q + 16'(src_xfer);
    for (int k = 0; k < 4; k++) begin
      slot_d[k] = slot_q[k];
      data_d[k] = data_q[k];
      if (k < c_num_dst) begin
        if (src_xfer && (sel_idx == k[1:0])) begin
          slot_d[k] = FULL;
          data_d[k] = i_data;
        end else if ((slot_q[k] == FULL) && i_ready[k]) begin
          slot_d[k] = EMPTY;
        end
      end else begin
        slot_d[k] = EMPTY;
        data_d[k] = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= EMPTY;
        data_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= slot_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign o_a     = data_q[0];
  assign o_b     = data_q[1];
  assign o_c     = data_q[2];
  assign o_d     = data_q[3];
  assign o_valid = {slot_q[3] == FULL, slot_q[2] == FULL,
                    slot_q[1] == FULL, slot_q[0] == FULL};
  assign o_cnt   = cnt_q;

endmodule
`default_nettype wire
